// File: rtl/fm_mod_tx_sequencer.sv
// fm_mod_tx_sequencer: burst sequencer feeding the FM modulator with LEAD/PREAMBLE/PAYLOAD/TAIL bits.
// Each bit lasts bit_div+1 clocks; zero-length phases are skipped without costing clocks.
module fm_mod_tx_sequencer #(
    parameter int CNT_W  = 16,
    parameter int TAIL_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              tx_start,
    input  logic              tx_abort,
    input  logic [CNT_W-1:0]  bitrate_div,
    input  logic [CNT_W-1:0]  lead_bits,
    input  logic [CNT_W-1:0]  preamble_bits,
    input  logic [CNT_W-1:0]  payload_bits,
    input  logic [TAIL_W-1:0] tail_bits,
    input  logic              data_in,
    input  logic              data_valid,
    output logic              data_ready,
    output logic              mod_data,
    output logic              mod_data_valid,
    output logic              mod_clk_out,
    output logic              mod_bit_en,
    output logic              busy,
    output logic              done,
    output logic              underflow,
    output logic [2:0]        state
);
    typedef enum logic [2:0] {
        IDLE = 3'd0, ARM = 3'd1, LEAD = 3'd2, PRE = 3'd3,
        PAY  = 3'd4, TAIL = 3'd5, DONE = 3'd6
    } state_t;

    state_t             st, nxt;
    logic [CNT_W-1:0]   bit_div, div_cnt, lead_rem, pre_rem, pay_rem;
    logic [TAIL_W-1:0]  tail_rem;
    logic               pre_bit, active, load;

    assign state = st;

    // Earlier phases are already drained, so the first nonzero counter is the next bit's phase.
    always_comb begin
        active     = (st == LEAD) || (st == PRE) || (st == PAY) || (st == TAIL);
        load       = (st == ARM) || (active && div_cnt == '0);
        nxt        = (lead_rem != '0) ? LEAD :
                     (pre_rem  != '0) ? PRE  :
                     (pay_rem  != '0) ? PAY  :
                     (tail_rem != '0) ? TAIL : DONE;
        data_ready = load && (nxt == PAY);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            st             <= IDLE;
            bit_div        <= '0;
            div_cnt        <= '0;
            lead_rem       <= '0;
            pre_rem        <= '0;
            pay_rem        <= '0;
            tail_rem       <= '0;
            pre_bit        <= 1'b0;
            mod_data       <= 1'b0;
            mod_data_valid <= 1'b0;
            mod_clk_out    <= 1'b0;
            mod_bit_en     <= 1'b0;
            busy           <= 1'b0;
            done           <= 1'b0;
            underflow      <= 1'b0;
        end else if (tx_abort && st != IDLE) begin
            st             <= IDLE;
            div_cnt        <= '0;
            mod_data       <= 1'b0;
            mod_data_valid <= 1'b0;
            mod_clk_out    <= 1'b0;
            mod_bit_en     <= 1'b0;
            busy           <= 1'b0;
            done           <= 1'b0;
        end else begin
            case (st)
                IDLE: begin
                    done <= 1'b0;
                    if (tx_start && !tx_abort) begin
                        st        <= ARM;
                        busy      <= 1'b1;
                        underflow <= 1'b0;
                        pre_bit   <= 1'b1;
                        bit_div   <= bitrate_div;
                        lead_rem  <= lead_bits;
                        pre_rem   <= preamble_bits;
                        pay_rem   <= payload_bits;
                        tail_rem  <= tail_bits;
                    end
                end
                DONE: begin
                    st   <= IDLE;
                    busy <= 1'b0;
                    done <= 1'b0;
                end
                default: begin
                    if (load && nxt == DONE) begin
                        st             <= DONE;
                        div_cnt        <= '0;
                        done           <= 1'b1;
                        mod_data       <= 1'b0;
                        mod_data_valid <= 1'b0;
                        mod_clk_out    <= 1'b0;
                        mod_bit_en     <= 1'b0;
                    end else if (load) begin
                        st             <= nxt;
                        div_cnt        <= bit_div;
                        mod_bit_en     <= 1'b1;
                        mod_clk_out    <= bit_div != '0;
                        mod_data_valid <= nxt != LEAD;
                        mod_data       <= (nxt == PRE) ? pre_bit :
                                          (nxt == PAY) ? (data_valid & data_in) : 1'b0;
                        if (nxt == LEAD)
                            lead_rem <= lead_rem - CNT_W'(1);
                        else if (nxt == PRE) begin
                            pre_rem <= pre_rem - CNT_W'(1);
                            pre_bit <= ~pre_bit;
                        end else if (nxt == PAY) begin
                            pay_rem <= pay_rem - CNT_W'(1);
                            if (!data_valid)
                                underflow <= 1'b1;
                        end else
                            tail_rem <= tail_rem - TAIL_W'(1);
                    end else begin
                        div_cnt     <= div_cnt - CNT_W'(1);
                        mod_bit_en  <= 1'b0;
                        mod_clk_out <= (div_cnt - CNT_W'(1)) > (bit_div >> 1);
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_fm_mod_tx_sequencer.sv
// tb_fm_mod_tx_sequencer: directed bench for the burst sequencer.
// Expected waveforms are derived per edge from the burst configuration, counting edges from the start request.
module tb_fm_mod_tx_sequencer;
    logic        clk = 1'b0;
    logic        reset, tx_start, tx_abort, data_in, data_valid;
    logic [15:0] bitrate_div, lead_bits, preamble_bits, payload_bits;
    logic [7:0]  tail_bits;
    logic        data_ready, mod_data, mod_data_valid, mod_clk_out, mod_bit_en;
    logic        busy, done, underflow;
    logic [2:0]  state;
    int          checks = 0, errors = 0;

    fm_mod_tx_sequencer dut (
        .clk(clk), .reset(reset), .tx_start(tx_start), .tx_abort(tx_abort),
        .bitrate_div(bitrate_div), .lead_bits(lead_bits), .preamble_bits(preamble_bits),
        .payload_bits(payload_bits), .tail_bits(tail_bits), .data_in(data_in),
        .data_valid(data_valid), .data_ready(data_ready), .mod_data(mod_data),
        .mod_data_valid(mod_data_valid), .mod_clk_out(mod_clk_out), .mod_bit_en(mod_bit_en),
        .busy(busy), .done(done), .underflow(underflow), .state(state)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d exp %0d", tag, got, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic config_set(input int div, input int ld, input int pr, input int py, input int tl);
        bitrate_div   = 16'(div);
        lead_bits     = 16'(ld);
        preamble_bits = 16'(pr);
        payload_bits  = 16'(py);
        tail_bits     = 8'(tl);
    endtask

    // div=3 lead=2 pre=4 pay=3 tail=2; the source answers each data_ready with the next pattern bit
    task automatic run_std(input logic [2:0] dpat, input logic [2:0] vpat, input bit disturb);
        int k, idx, st_e;
        logic uf, md_e;
        k  = 0;
        uf = 1'b0;
        config_set(3, 2, 4, 3, 2);
        tx_start = 1'b1;
        for (int e = 1; e <= 47; e++) begin
            step();
            if (e == 1) tx_start = 1'b0;
            st_e = (e == 1) ? 1 : (e <= 9) ? 2 : (e <= 25) ? 3 : (e <= 37) ? 4 :
                   (e <= 45) ? 5 : (e == 46) ? 6 : 0;
            idx  = (e >= 26 && e <= 37) ? (e - 26) / 4 : 0;
            md_e = (st_e == 3) ? (((e - 10) / 4) % 2 == 0) :
                   (st_e == 4) ? (dpat[idx] & vpat[idx]) : 1'b0;
            if (st_e == 4 && !vpat[idx]) uf = 1'b1;
            check("state", 32'(state), 32'(st_e));
            check("busy", 32'(busy), 32'(e <= 46));
            check("bit_en", 32'(mod_bit_en), 32'(e >= 2 && e <= 42 && (e - 2) % 4 == 0));
            check("mod_valid", 32'(mod_data_valid), 32'(e >= 10 && e <= 45));
            check("mod_data", 32'(mod_data), 32'(md_e));
            check("mod_clk", 32'(mod_clk_out), 32'(e >= 2 && e <= 45 && (e - 2) % 4 < 2));
            check("done", 32'(done), 32'(e == 46));
            check("ready", 32'(data_ready), 32'(e == 25 || e == 29 || e == 33));
            check("underflow", 32'(underflow), 32'(uf));
            if (data_ready && k < 3) begin
                data_in    = dpat[k];
                data_valid = vpat[k];
                k++;
            end
            if (disturb && e == 12) config_set(7, 9, 1, 1, 5);
            if (disturb && e == 15) tx_start = 1'b1;
            if (disturb && e == 16) tx_start = 1'b0;
        end
    endtask

    initial begin
        reset = 1'b1; tx_start = 1'b0; tx_abort = 1'b0; data_in = 1'b0; data_valid = 1'b0;
        config_set(0, 0, 0, 0, 0);
        step(); step();
        reset = 1'b0;
        step();
        check("rst_state", 32'(state), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_outs", {26'd0, mod_data, mod_data_valid, mod_clk_out, mod_bit_en, done, underflow}, 0);
        check("rst_ready", 32'(data_ready), 0);

        run_std(3'b101, 3'b111, 1'b1);
        run_std(3'b111, 3'b101, 1'b0);

        // single payload bit at div=0; the start also clears the sticky underflow
        config_set(0, 0, 0, 1, 0);
        tx_start = 1'b1;
        step(); tx_start = 1'b0;
        check("s_arm", 32'(state), 1);
        check("s_arm_ready", 32'(data_ready), 1);
        check("s_uf_clr", 32'(underflow), 0);
        data_in = 1'b1; data_valid = 1'b1;
        step();
        check("s_pay", 32'(state), 4);
        check("s_bit", {29'd0, mod_bit_en, mod_data_valid, mod_data}, 7);
        check("s_clk", 32'(mod_clk_out), 0);
        check("s_ready", 32'(data_ready), 0);
        step();
        check("s_done_st", 32'(state), 6);
        check("s_done", 32'(done), 1);
        step();
        check("s_idle", 32'(state), 0);
        check("s_busy", 32'(busy), 0);

        // all lengths zero
        config_set(5, 0, 0, 0, 0);
        tx_start = 1'b1;
        step(); tx_start = 1'b0;
        check("z_arm", 32'(state), 1);
        check("z_ready", 32'(data_ready), 0);
        step();
        check("z_done_st", 32'(state), 6);
        check("z_done", 32'(done), 1);
        check("z_bit_en", 32'(mod_bit_en), 0);
        step();
        check("z_idle", 32'(state), 0);

        // abort inside the first preamble bit
        config_set(3, 2, 4, 3, 2);
        tx_start = 1'b1;
        for (int e = 1; e <= 12; e++) begin
            step();
            tx_start = 1'b0;
        end
        check("a_pre", 32'(state), 3);
        check("a_pre_data", {30'd0, mod_data_valid, mod_data}, 3);
        tx_abort = 1'b1;
        step();
        tx_abort = 1'b0;
        check("a_idle", 32'(state), 0);
        check("a_busy", 32'(busy), 0);
        check("a_outs", {28'd0, mod_data, mod_data_valid, mod_clk_out, mod_bit_en}, 0);
        check("a_done", 32'(done), 0);
        for (int e = 0; e < 3; e++) begin
            step();
            check("a_no_done", {30'd0, done, busy}, 0);
        end
        tx_start = 1'b1; tx_abort = 1'b1;
        step();
        check("sa_idle", 32'(state), 0);
        check("sa_busy", 32'(busy), 0);
        tx_start = 1'b0; tx_abort = 1'b0;
        step();
        check("sa_stay", 32'(state), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
